// File: rtl/uart_rx_framer_if.sv
// Receive-side byte handshake and frame status between the UART framer and its consumer.
interface uart_rx_framer_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    modport master (
        output data_out, data_valid, frame_err, parity_err, overrun,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, frame_err, parity_err, overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_framer.sv
// UART receiver: synchronizes the serial line, frames 8N1 / 8[EO]1 characters and
// hands good bytes to a single-entry holding register with valid/ready.
module uart_rx_framer #(
    parameter int CLKS_PER_BIT = 2000,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx,
    uart_rx_framer_if.master rx_if
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] END_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic             rx_sync_p0, rx_s, rx_prev;
    logic [1:0]       sync_flush;
    logic             line_armed;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic             par_fault;
    logic             cnt_clr, shift_en, par_en, stop_en;
    logic             start_det, bit_tick, good_byte;
    logic [7:0]       data_q;
    logic             valid_q, frame_err_q, parity_err_q, overrun_q;

    // Synchronizer; the line only arms once a real high level has come through it,
    // so the reset value of the flops cannot fake a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_p0 <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            sync_flush <= 2'b00;
            line_armed <= 1'b0;
        end else begin
            rx_sync_p0 <= uart_rx;
            rx_s       <= rx_sync_p0;
            rx_prev    <= rx_s;
            sync_flush <= {sync_flush[0], 1'b1};
            if (sync_flush[1] && rx_s)
                line_armed <= 1'b1;
        end
    end

    assign start_det = line_armed && rx_prev && !rx_s;
    assign bit_tick  = (cnt == END_CNT);
    assign good_byte = stop_en && rx_s && !par_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start_det) begin
                    state_nxt = START;
                    cnt_clr   = 1'b1;
                end
            end
            START: begin
                if (cnt == MID_CNT) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_en = 1'b1;
                    if (idx == 3'd7)
                        state_nxt = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    par_en    = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    stop_en   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // After the mid-start re-centre, every counter wrap lands on a bit centre.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            par_fault <= 1'b0;
        end else begin
            if (cnt_clr || bit_tick || state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (cnt_clr)
                idx <= 3'd0;
            else if (shift_en)
                idx <= idx + 3'd1;
            if (shift_en)
                shift <= {rx_s, shift[7:1]};
            if (state == IDLE)
                par_fault <= 1'b0;
            else if (par_en)
                par_fault <= (rx_s != ((^shift) ^ PARITY_ODD));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= stop_en && !rx_s;
            parity_err_q <= stop_en && rx_s && par_fault;
            overrun_q    <= 1'b0;
            if (good_byte) begin
                if (!valid_q || rx_if.data_ready) begin
                    data_q  <= shift;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && rx_if.data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.data_out   = data_q;
    assign rx_if.data_valid = valid_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: one plain 8N1 instance and one even-parity instance,
// driven with directed and random frames against a frame-level reference model.
module tb_uart_rx_framer;

    localparam int C    = 16;
    localparam int HALF = C / 2;

    logic clk = 1'b0;
    logic rst_n;
    logic rx[2];
    logic ready[2];
    always #5 clk = ~clk;

    uart_rx_framer_if if0();
    uart_rx_framer_if if1();
    assign if0.data_ready = ready[0];
    assign if1.data_ready = ready[1];

    uart_rx_framer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx[0]), .rx_if(if0));
    uart_rx_framer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx[1]), .rx_if(if1));

    logic [7:0] dout[2];
    logic       dv[2], fe[2], pe[2], ov[2];
    assign dout[0] = if0.data_out;   assign dout[1] = if1.data_out;
    assign dv[0]   = if0.data_valid; assign dv[1]   = if1.data_valid;
    assign fe[0]   = if0.frame_err;  assign fe[1]   = if1.frame_err;
    assign pe[0]   = if0.parity_err; assign pe[1]   = if1.parity_err;
    assign ov[0]   = if0.overrun;    assign ov[1]   = if1.overrun;

    // Pulse counters and data_valid rise time, sampled on the falling edge.
    int   cyc = 0;
    int   fe_cnt[2], pe_cnt[2], ov_cnt[2], rise_cyc[2];
    logic dv_q[2];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (fe[w] === 1'b1) fe_cnt[w] <= fe_cnt[w] + 1;
            if (pe[w] === 1'b1) pe_cnt[w] <= pe_cnt[w] + 1;
            if (ov[w] === 1'b1) ov_cnt[w] <= ov_cnt[w] + 1;
            if (dv[w] === 1'b1 && dv_q[w] !== 1'b1) rise_cyc[w] <= cyc;
            dv_q[w] <= dv[w];
        end
    end

    // Reference model: holding register contents and expected pulse totals.
    bit         hv[2];
    logic [7:0] hd[2];
    int         exp_fe[2], exp_pe[2], exp_ov[2];
    int         fall_cyc[2];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic model_frame(input int w, input logic [7:0] d, input bit p, input bit s);
        bit pen = (w == 1);
        if (!s)                        exp_fe[w]++;
        else if (pen && (p != (^d)))   exp_pe[w]++;
        else if (!hv[w]) begin hv[w] = 1'b1; hd[w] = d; end
        else                           exp_ov[w]++;
    endtask

    task automatic send_frame(input int w, input logic [7:0] d, input bit p, input bit s,
                              input int idle_bits);
        @(negedge clk);
        rx[w] = 1'b0; fall_cyc[w] = cyc;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx[w] = d[i];
            repeat (C) @(negedge clk);
        end
        if (w == 1) begin
            rx[w] = p;
            repeat (C) @(negedge clk);
        end
        rx[w] = s;
        repeat (C) @(negedge clk);
        rx[w] = 1'b1;
        repeat (idle_bits * C) @(negedge clk);
        model_frame(w, d, p, s);
    endtask

    task automatic consume(input int w);
        @(negedge clk); ready[w] = 1'b1;
        @(negedge clk); ready[w] = 1'b0;
        hv[w] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            n_checks++; if (dout[w] !== 8'h00) begin n_fail++; $display("FAIL reset_dout[%0d] got %h want 00", w, dout[w]); end
            n_checks++; if (dv[w] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d] got %b want 0", w, dv[w]); end
            n_checks++; if ({fe[w], pe[w], ov[w]} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses[%0d] got %b want 000", w, {fe[w], pe[w], ov[w]}); end
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_hold();
        int lat;
        int want = 2 + HALF + 9 * C + 1;
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1);
        n_checks++; if (dv[0] !== 1'b1) begin n_fail++; $display("FAIL hold_valid got %b want 1", dv[0]); end
        n_checks++; if (dout[0] !== 8'hA5) begin n_fail++; $display("FAIL hold_data got %h want a5", dout[0]); end
        lat = rise_cyc[0] - fall_cyc[0];
        n_checks++; if (lat < want - 1 || lat > want + 1) begin n_fail++; $display("FAIL hold_latency got %0d want %0d+-1", lat, want); end
        repeat (40) @(negedge clk);
        n_checks++; if (dv[0] !== 1'b1 || dout[0] !== 8'hA5) begin n_fail++; $display("FAIL hold_stable got %b/%h want 1/a5", dv[0], dout[0]); end
        consume(0);
        n_checks++; if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL hold_consume got %b want 0", dv[0]); end
        n_checks++; if (fe_cnt[0] + pe_cnt[0] + ov_cnt[0] !== 0) begin n_fail++; $display("FAIL hold_no_err got %0d want 0", fe_cnt[0] + pe_cnt[0] + ov_cnt[0]); end
    endtask

    task automatic test_false_start();
        @(negedge clk); rx[0] = 1'b0;
        repeat (4) @(negedge clk); rx[0] = 1'b1;
        repeat (3 * C) @(negedge clk);
        ready[0] = 1'b1;
        repeat (5) @(negedge clk);
        ready[0] = 1'b0;
        n_checks++; if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL false_valid got %b want 0", dv[0]); end
        n_checks++; if (dout[0] !== hd[0]) begin n_fail++; $display("FAIL false_data got %h want %h", dout[0], hd[0]); end
        n_checks++; if (fe_cnt[0] !== exp_fe[0] || pe_cnt[0] !== exp_pe[0] || ov_cnt[0] !== exp_ov[0]) begin
            n_fail++; $display("FAIL false_pulses got %0d/%0d/%0d want %0d/%0d/%0d", fe_cnt[0], pe_cnt[0], ov_cnt[0], exp_fe[0], exp_pe[0], exp_ov[0]); end
    endtask

    task automatic test_frame_err();
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1);
        n_checks++; if (fe_cnt[0] !== exp_fe[0]) begin n_fail++; $display("FAIL ferr_count got %0d want %0d", fe_cnt[0], exp_fe[0]); end
        n_checks++; if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL ferr_valid got %b want 0", dv[0]); end
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1);
        n_checks++; if (dv[0] !== 1'b1 || dout[0] !== 8'h5A) begin n_fail++; $display("FAIL ferr_next got %b/%h want 1/5a", dv[0], dout[0]); end
        n_checks++; if (fe_cnt[0] !== exp_fe[0]) begin n_fail++; $display("FAIL ferr_recount got %0d want %0d", fe_cnt[0], exp_fe[0]); end
        consume(0);
    endtask

    task automatic test_back_to_back();
        send_frame(0, 8'h11, 1'b0, 1'b1, 0);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1);
        n_checks++; if (dv[0] !== 1'b1 || dout[0] !== 8'h11) begin n_fail++; $display("FAIL b2b_data got %b/%h want 1/11", dv[0], dout[0]); end
        n_checks++; if (ov_cnt[0] !== exp_ov[0]) begin n_fail++; $display("FAIL b2b_overrun got %0d want %0d", ov_cnt[0], exp_ov[0]); end
    endtask

    task automatic test_parity();
        int lat;
        int want = 2 + HALF + 10 * C + 1;
        send_frame(1, 8'h0F, 1'b1, 1'b1, 1);
        n_checks++; if (pe_cnt[1] !== exp_pe[1]) begin n_fail++; $display("FAIL par_err_count got %0d want %0d", pe_cnt[1], exp_pe[1]); end
        n_checks++; if (dv[1] !== 1'b0) begin n_fail++; $display("FAIL par_err_valid got %b want 0", dv[1]); end
        send_frame(1, 8'h0F, 1'b0, 1'b1, 1);
        n_checks++; if (dv[1] !== 1'b1 || dout[1] !== 8'h0F) begin n_fail++; $display("FAIL par_good got %b/%h want 1/0f", dv[1], dout[1]); end
        lat = rise_cyc[1] - fall_cyc[1];
        n_checks++; if (lat < want - 1 || lat > want + 1) begin n_fail++; $display("FAIL par_latency got %0d want %0d+-1", lat, want); end
        consume(1);
        send_frame(1, 8'h0F, 1'b1, 1'b0, 1);
        n_checks++; if (fe_cnt[1] !== exp_fe[1] || pe_cnt[1] !== exp_pe[1]) begin
            n_fail++; $display("FAIL par_both got fe %0d pe %0d want fe %0d pe %0d", fe_cnt[1], pe_cnt[1], exp_fe[1], exp_pe[1]); end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk); rx[0] = 1'b0;
        repeat (C) @(negedge clk);
        rx[0] = 1'b1;
        repeat (4 * C + HALF) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (dv[0] !== 1'b0 || dout[0] !== 8'h00) begin n_fail++; $display("FAIL rst_mid_out got %b/%h want 0/00", dv[0], dout[0]); end
        rst_n = 1'b1;
        for (int w = 0; w < 2; w++) begin hv[w] = 1'b0; hd[w] = 8'h00; end
        repeat (HALF + 5 * C) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            n_checks++; if (dv[w] !== 1'b0 || dout[w] !== 8'h00) begin n_fail++; $display("FAIL rst_after[%0d] got %b/%h want 0/00", w, dv[w], dout[w]); end
            n_checks++; if (fe_cnt[w] !== exp_fe[w] || pe_cnt[w] !== exp_pe[w] || ov_cnt[w] !== exp_ov[w]) begin
                n_fail++; $display("FAIL rst_pulses[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", w, fe_cnt[w], pe_cnt[w], ov_cnt[w], exp_fe[w], exp_pe[w], exp_ov[w]); end
        end
        // Line low across reset release must not look like a start bit.
        rx[0] = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * C) @(negedge clk);
        rx[0] = 1'b1;
        repeat (2 * C) @(negedge clk);
        n_checks++; if (dv[0] !== 1'b0 || fe_cnt[0] !== exp_fe[0]) begin n_fail++; $display("FAIL rst_low_release got %b/%0d want 0/%0d", dv[0], fe_cnt[0], exp_fe[0]); end
        send_frame(0, 8'h81, 1'b0, 1'b1, 1);
        n_checks++; if (dv[0] !== 1'b1 || dout[0] !== 8'h81) begin n_fail++; $display("FAIL rst_next got %b/%h want 1/81", dv[0], dout[0]); end
        consume(0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int         w = int'($urandom_range(0, 1));
            logic [7:0] d = 8'($urandom);
            bit         s = ($urandom_range(0, 7) != 0);
            bit         p = 1'($urandom_range(0, 1));
            send_frame(w, d, p, s, 1);
            n_checks++; if (dv[w] !== hv[w] || dout[w] !== hd[w]) begin
                n_fail++; $display("FAIL rand%0d_hold[%0d] got %b/%h want %b/%h", n, w, dv[w], dout[w], hv[w], hd[w]); end
            n_checks++; if (fe_cnt[w] !== exp_fe[w] || pe_cnt[w] !== exp_pe[w] || ov_cnt[w] !== exp_ov[w]) begin
                n_fail++; $display("FAIL rand%0d_pulses[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", n, w, fe_cnt[w], pe_cnt[w], ov_cnt[w], exp_fe[w], exp_pe[w], exp_ov[w]); end
            if ($urandom_range(0, 2) == 0) consume(w);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int w = 0; w < 2; w++) begin rx[w] = 1'b1; ready[w] = 1'b0; hd[w] = 8'h00; end
        test_reset();
        test_hold();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_parity();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d cycles", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 The block SHALL have the following parameters:
- CLKS_PER_BIT, default 2000, clk cycles per bit time; legal values are even integers >= 4.
- PARITY_EN, default 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, default 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.

REQ-002 The block SHALL have the following ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous, active-low reset.
- uart_rx  input  1  serial line, asynchronous to clk, idle high.
- data_out  output  8  received byte, LSB = first data bit on the line.
- data_valid  output  1  data_out holds an unconsumed byte.
- data_ready  input  1  consumer accepts data_out on a clk edge where data_valid = 1.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- parity_err  output  1  one-cycle pulse: parity mismatch.
- overrun  output  1  one-cycle pulse: a good byte was dropped because the holding register was full.

Function
REQ-003 uart_rx SHALL pass through a 2-flop synchronizer; only the synchronized value (rx_s) is used internally.
REQ-004 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, plus a bit-time counter of width clog2(CLKS_PER_BIT) and a 3-bit data-bit index.
REQ-005 IDLE: a start SHALL be detected when rx_s is 0 and was 1 on the previous cycle; on detection go to START and clear the counter. A line held low SHALL NOT re-trigger.
REQ-006 START: sample rx_s when the counter reaches CLKS_PER_BIT/2-1 (mid-bit).
- Sample = 0: go to DATA and clear the counter.
- Sample = 1: false start; go to IDLE with no output activity.
REQ-007 DATA: sample rx_s every CLKS_PER_BIT cycles, i.e. at each mid-bit, and shift it in LSB first.
- After the 8th sample, go to PARITY if PARITY_EN = 1, otherwise go to STOP.
REQ-008 PARITY: sample one bit at mid-bit.
- Expected value = XOR of the 8 data bits, inverted when PARITY_ODD = 1.
- On mismatch, record a parity fault for this frame.
REQ-009 STOP: sample at mid-bit, then go to IDLE immediately without waiting for the bit end.
REQ-010 Frame outcome is decided on the stop sample, with the action taking effect on the next clk edge:
- Stop = 0: pulse frame_err; discard the byte.
- Otherwise, parity fault recorded: pulse parity_err; discard the byte.
- Otherwise, the frame is good.
- If both a framing and a parity fault occur, only frame_err pulses.
REQ-011 Good byte with the holding register empty, or with data_valid = 1 and data_ready = 1 in the same cycle: load data_out and set data_valid = 1.
REQ-012 Good byte with data_valid = 1 and data_ready = 0: pulse overrun, drop the new byte, and leave data_out/data_valid unchanged.
REQ-013 data_valid SHALL clear on the edge where data_valid = 1 and data_ready = 1, unless REQ-011 reloads it in that same edge. data_out SHALL remain stable while data_valid = 1.
REQ-014 data_ready while data_valid = 0 SHALL have no effect.
REQ-015 Latency: data_valid rises 2 + CLKS_PER_BIT/2 + (9 + PARITY_EN)*CLKS_PER_BIT + 1 cycles after the uart_rx falling edge, within ±1 cycle of synchronizer uncertainty.
REQ-016 The counter SHALL wrap to 0 at CLKS_PER_BIT-1; no other counter value is a sample point.

Reset
REQ-017 While rst_n = 0, the block SHALL hold the following values:
- FSM = IDLE; counter, index and shift register = 0.
- Synchronizer flops and previous-rx flop = 1.
- data_out = 8'h00; data_valid, frame_err, parity_err and overrun = 0.
REQ-018 Reset asserted mid-frame SHALL abort the frame with no output pulse.
- After release, reception resumes only on a new 1->0 edge of rx_s.
- A line that is low at release SHALL NOT start a frame.

Verification (CLKS_PER_BIT = 16 unless noted)
REQ-019 Frame 0xA5 with a good stop bit, data_ready = 0 -> data_out = 8'hA5, data_valid = 1 held until data_ready is pulsed, then 0; no error pulses.
REQ-020 uart_rx low for 4 clk, then high -> FSM returns to IDLE; data_valid, frame_err, parity_err and overrun all stay 0.
REQ-021 Frame 0x3C with stop bit = 0 -> one frame_err pulse, data_valid stays 0; the next frame 0x5A is received correctly.
REQ-022 Frames 0x11 then 0x22 back to back, data_ready = 0 -> data_out = 8'h11 valid; one overrun pulse at the 0x22 stop sample; data_out remains 8'h11.
REQ-023 PARITY_EN = 1, PARITY_ODD = 0, frame 0x0F with parity bit 1 -> one parity_err pulse, no data_valid; the same frame with parity bit 0 gives data_out = 8'h0F.
REQ-024 rst_n pulsed low during data bit 4 of frame 0xFF -> all outputs return to reset values; no pulse occurs; the following frame 0x81 is received correctly.
